// File: rtl/tag_manchester_decoder.sv
// Manchester half-bit decoder for tag responses from the HF demodulator.
// Frames open with a (1,0) start pair, carry LSB-first data bytes each followed
// by an odd-parity bit, and close on a (0,0) pair. A (1,1) pair is a collision.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for the first half of the start-of-frame pair
// SOC2  | first SOC half seen (1); second half must be 0
// RX_H1 | in frame, waiting for the first half-bit of a pair
// RX_H2 | in frame, first half latched, waiting for the second half
module tag_manchester_decoder #(
    parameter int MAX_BYTES = 64
) (
    input  logic       osc_clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic       curbit,
    input  logic       enable,
    output logic [7:0] byte_data,
    output logic [3:0] byte_bits,
    output logic       byte_valid,
    output logic       byte_parity_err,
    output logic       frame_active,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] frame_len
);

    typedef enum logic [1:0] {IDLE, SOC2, RX_H1, RX_H2} state_t;

    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

    state_t      state_q, state_d;
    logic        h1_q, h1_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        done_pend_q, done_pend_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic [3:0]  byte_bits_q, byte_bits_d;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_parity_err_q, byte_parity_err_d;
    logic        frame_active_q, frame_active_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  frame_len_q, frame_len_d;

    // State and output registers; everything runs on the demodulator's falling edge.
    always_ff @(negedge osc_clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            h1_q              <= 1'b0;
            cnt_q             <= 4'd0;
            sr_q              <= 8'd0;
            done_pend_q       <= 1'b0;
            byte_data_q       <= 8'd0;
            byte_bits_q       <= 4'd0;
            byte_valid_q      <= 1'b0;
            byte_parity_err_q <= 1'b0;
            frame_active_q    <= 1'b0;
            frame_done_q      <= 1'b0;
            frame_err_q       <= 1'b0;
            frame_len_q       <= 8'd0;
        end else begin
            state_q           <= state_d;
            h1_q              <= h1_d;
            cnt_q             <= cnt_d;
            sr_q              <= sr_d;
            done_pend_q       <= done_pend_d;
            byte_data_q       <= byte_data_d;
            byte_bits_q       <= byte_bits_d;
            byte_valid_q      <= byte_valid_d;
            byte_parity_err_q <= byte_parity_err_d;
            frame_active_q    <= frame_active_d;
            frame_done_q      <= frame_done_d;
            frame_err_q       <= frame_err_d;
            frame_len_q       <= frame_len_d;
        end
    end

    // Next-state and output decode. A trailing partial byte at EOF defers
    // frame_done by one cycle (done_pend) so it never overlaps byte_valid.
    always_comb begin
        state_d           = state_q;
        h1_d              = h1_q;
        cnt_d             = cnt_q;
        sr_d              = sr_q;
        done_pend_d       = 1'b0;
        byte_data_d       = byte_data_q;
        byte_bits_d       = byte_bits_q;
        byte_valid_d      = 1'b0;
        byte_parity_err_d = byte_parity_err_q;
        frame_active_d    = frame_active_q;
        frame_done_d      = 1'b0;
        frame_err_d       = frame_err_q;
        frame_len_d       = frame_len_q;

        if (done_pend_q) begin
            state_d        = IDLE;
            frame_done_d   = 1'b1;
            frame_err_d    = 1'b0;
            frame_active_d = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
            if (frame_active_q) begin
                frame_done_d   = 1'b1;
                frame_err_d    = 1'b1;
                frame_active_d = 1'b0;
            end
        end else if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (curbit) state_d = SOC2;
                end
                SOC2: begin
                    if (!curbit) begin
                        state_d        = RX_H1;
                        frame_active_d = 1'b1;
                        cnt_d          = 4'd0;
                        sr_d           = 8'd0;
                        frame_len_d    = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RX_H1: begin
                    h1_d    = curbit;
                    state_d = RX_H2;
                end
                RX_H2: begin
                    state_d = RX_H1;
                    if (h1_q != curbit) begin
                        // Valid data symbol; its value equals the first half.
                        if (cnt_q == 4'd8) begin
                            byte_valid_d      = 1'b1;
                            byte_data_d       = sr_q;
                            byte_bits_d       = 4'd8;
                            byte_parity_err_d = ~(^sr_q ^ h1_q);
                            cnt_d             = 4'd0;
                            sr_d              = 8'd0;
                            frame_len_d       = (frame_len_q == 8'hFF) ? frame_len_q
                                                                       : frame_len_q + 8'd1;
                        end else if ({24'd0, frame_len_q} >= MAX_LEN) begin
                            state_d        = IDLE;
                            frame_done_d   = 1'b1;
                            frame_err_d    = 1'b1;
                            frame_active_d = 1'b0;
                        end else begin
                            sr_d[cnt_q[2:0]] = h1_q;
                            cnt_d            = cnt_q + 4'd1;
                        end
                    end else if (!curbit) begin
                        state_d = IDLE;
                        if (cnt_q != 4'd0) begin
                            byte_valid_d      = 1'b1;
                            byte_data_d       = sr_q;
                            byte_bits_d       = cnt_q;
                            byte_parity_err_d = 1'b0;
                            done_pend_d       = 1'b1;
                        end else begin
                            frame_done_d   = 1'b1;
                            frame_err_d    = 1'b0;
                            frame_active_d = 1'b0;
                        end
                    end else begin
                        state_d        = IDLE;
                        frame_done_d   = 1'b1;
                        frame_err_d    = 1'b1;
                        frame_active_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_data       = byte_data_q;
    assign byte_bits       = byte_bits_q;
    assign byte_valid      = byte_valid_q;
    assign byte_parity_err = byte_parity_err_q;
    assign frame_active    = frame_active_q;
    assign frame_done      = frame_done_q;
    assign frame_err       = frame_err_q;
    assign frame_len       = frame_len_q;

endmodule

// File: tb/tb_tag_manchester_decoder.sv
// Bench for tag_manchester_decoder: a half-bit stream model predicts byte and
// end-of-frame events with their cycle; a posedge monitor checks the DUT.
module tb_tag_manchester_decoder;

    localparam int MAXB = 2;

    logic       osc_clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic       curbit = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] byte_data;
    logic [3:0] byte_bits;
    logic       byte_valid;
    logic       byte_parity_err;
    logic       frame_active;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_len;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int cyc; int data; int bits; int perr;} bev_t;
    typedef struct {int cyc; int err; int len;} dev_t;
    bev_t bq[$];
    dev_t dq[$];

    // model state
    bit mf = 0, msoc = 0, mhalf = 0, mh1 = 0;
    bit mbits[$];
    int mlen = 0;

    // monitor record
    int nbytes = 0, ndone = 0;
    int last_data = 0, last_bits = 0, last_perr = 0, last_len = 0, last_ferr = 0;
    int b0, d0;

    tag_manchester_decoder #(.MAX_BYTES(MAXB)) dut (
        .osc_clk(osc_clk), .reset(reset), .sample_valid(sample_valid),
        .curbit(curbit), .enable(enable), .byte_data(byte_data),
        .byte_bits(byte_bits), .byte_valid(byte_valid),
        .byte_parity_err(byte_parity_err), .frame_active(frame_active),
        .frame_done(frame_done), .frame_err(frame_err), .frame_len(frame_len)
    );

    always #5 osc_clk = ~osc_clk;
    always @(negedge osc_clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pack_bits();
        int v = 0;
        for (int i = 0; i < mbits.size(); i++) if (mbits[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic push_byte(input int data, input int bits, input int perr, input int c);
        bev_t e;
        e.cyc = c; e.data = data; e.bits = bits; e.perr = perr;
        bq.push_back(e);
    endtask

    task automatic push_done(input int err, input int c);
        dev_t e;
        e.cyc = c; e.err = err; e.len = mlen;
        dq.push_back(e);
    endtask

    // Frame-level model: what each received half-bit means for the frame.
    task automatic model_sample(input bit b, input int c);
        int d;
        if (!mf) begin
            if (msoc) begin
                msoc = 0;
                if (!b) begin mf = 1; mhalf = 0; mbits.delete(); mlen = 0; end
            end else if (b) msoc = 1;
        end else if (!mhalf) begin
            mh1 = b; mhalf = 1;
        end else begin
            mhalf = 0;
            if (mh1 != b) begin
                if (mbits.size() == 8) begin
                    d = pack_bits();
                    push_byte(d, 8, (($countones(d) + int'(mh1)) % 2 == 0) ? 1 : 0, c);
                    mlen = (mlen < 255) ? mlen + 1 : 255;
                    mbits.delete();
                end else if (mbits.size() == 0 && mlen >= MAXB) begin
                    push_done(1, c); mf = 0;
                end else mbits.push_back(mh1);
            end else if (!b) begin
                if (mbits.size() > 0) begin
                    push_byte(pack_bits(), mbits.size(), 0, c);
                    push_done(0, c + 1);
                end else push_done(0, c);
                mf = 0;
            end else begin
                push_done(1, c); mf = 0;
            end
        end
    endtask

    task automatic model_reset();
        mf = 0; msoc = 0; mhalf = 0; mlen = 0; mbits.delete();
        bq.delete(); dq.delete();
    endtask

    task automatic send_half(input bit b);
        @(posedge osc_clk);
        sample_valid = 1'b1; curbit = b;
        if (enable) model_sample(b, cyc + 1);
        @(posedge osc_clk);
        sample_valid = 1'b0; curbit = 1'b0;
    endtask

    task automatic send_pair(input bit a, input bit b);
        send_half(a); send_half(b);
    endtask

    task automatic send_bit(input bit b);
        if (b) send_pair(1, 0); else send_pair(0, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit p);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge osc_clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_byte_data"}, int'(byte_data), 0);
        chk({tag, "_byte_bits"}, int'(byte_bits), 0);
        chk({tag, "_byte_valid"}, int'(byte_valid), 0);
        chk({tag, "_perr"}, int'(byte_parity_err), 0);
        chk({tag, "_active"}, int'(frame_active), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
        chk({tag, "_len"}, int'(frame_len), 0);
    endtask

    // Monitor: every posedge (half a cycle after the DUT edge) match pulses to the model.
    always @(posedge osc_clk) begin
        if (byte_valid && frame_done) chk("bv_fd_overlap", 1, 0);
        if (byte_valid) begin
            if (bq.size() == 0 || bq[0].cyc != cyc) chk("unexpected_byte_valid", 1, 0);
            else begin
                chk("byte_data", int'(byte_data), bq[0].data);
                chk("byte_bits", int'(byte_bits), bq[0].bits);
                chk("byte_parity_err", int'(byte_parity_err), bq[0].perr);
                chk("active_at_byte", int'(frame_active), 1);
                void'(bq.pop_front());
            end
            nbytes++;
            last_data = int'(byte_data); last_bits = int'(byte_bits);
            last_perr = int'(byte_parity_err);
        end
        while (bq.size() > 0 && bq[0].cyc <= cyc) begin
            chk("missing_byte_valid", 0, 1);
            void'(bq.pop_front());
        end
        if (frame_done) begin
            if (dq.size() == 0 || dq[0].cyc != cyc) chk("unexpected_frame_done", 1, 0);
            else begin
                chk("frame_err", int'(frame_err), dq[0].err);
                chk("frame_len", int'(frame_len), dq[0].len);
                chk("active_at_done", int'(frame_active), 0);
                void'(dq.pop_front());
            end
            ndone++;
            last_len = int'(frame_len); last_ferr = int'(frame_err);
        end
        while (dq.size() > 0 && dq[0].cyc <= cyc) begin
            chk("missing_frame_done", 0, 1);
            void'(dq.pop_front());
        end
    end

    initial begin
        idle(3);
        check_zero("reset");
        reset = 1'b0;
        idle(3);

        // single byte 0x04, good parity
        b0 = nbytes; d0 = ndone;
        send_pair(1, 0); send_byte(8'h04, 1'b0); send_pair(0, 0); idle(6);
        chk("t1_nbytes", nbytes - b0, 1); chk("t1_ndone", ndone - d0, 1);
        chk("t1_data", last_data, 'h04); chk("t1_bits", last_bits, 8);
        chk("t1_perr", last_perr, 0); chk("t1_len", last_len, 1); chk("t1_ferr", last_ferr, 0);

        // same byte, bad parity
        send_pair(1, 0); send_byte(8'h04, 1'b1); send_pair(0, 0); idle(6);
        chk("t2_perr", last_perr, 1); chk("t2_ferr", last_ferr, 0);

        // partial byte 1,0,1,0
        send_pair(1, 0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_pair(0, 0); idle(6);
        chk("t3_data", last_data, 'h05); chk("t3_bits", last_bits, 4);
        chk("t3_perr", last_perr, 0); chk("t3_len", last_len, 0);

        // collision after 3 bits
        b0 = nbytes; d0 = ndone;
        send_pair(1, 0); send_bit(1); send_bit(1); send_bit(0);
        send_pair(1, 1); idle(6);
        chk("t4_nbytes", nbytes - b0, 0); chk("t4_ndone", ndone - d0, 1);
        chk("t4_ferr", last_ferr, 1); chk("t4_active", int'(frame_active), 0);

        // 1,1 in IDLE, then a normal frame
        send_pair(1, 1); idle(2);
        chk("t5_active_idle", int'(frame_active), 0);
        send_pair(1, 0); send_byte(8'hA5, 1'b1); send_pair(0, 0); idle(6);
        chk("t5_data", last_data, 'hA5); chk("t5_perr", last_perr, 0); chk("t5_len", last_len, 1);

        // exactly MAX bytes then EOF
        send_pair(1, 0); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_pair(0, 0); idle(6);
        chk("t6_len", last_len, 2); chk("t6_ferr", last_ferr, 0);

        // overflow on the first data bit beyond MAX bytes
        b0 = nbytes; d0 = ndone;
        send_pair(1, 0); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
        send_bit(1); idle(6);
        chk("t7_nbytes", nbytes - b0, 2); chk("t7_ndone", ndone - d0, 1);
        chk("t7_perr", last_perr, 1); chk("t7_ferr", last_ferr, 1); chk("t7_len", last_len, 2);

        // 8 data bits, parity missing
        send_pair(1, 0);
        for (int i = 0; i < 8; i++) send_bit(((8'hC3 >> i) & 1) != 0);
        send_pair(0, 0); idle(6);
        chk("t8_data", last_data, 'hC3); chk("t8_bits", last_bits, 8); chk("t8_len", last_len, 0);

        // enable dropped mid-frame
        d0 = ndone;
        send_pair(1, 0); send_bit(1); send_bit(0); send_bit(1);
        @(posedge osc_clk);
        enable = 1'b0;
        if (mf) push_done(1, cyc + 1);
        mf = 0; msoc = 0; mhalf = 0; mbits.delete();
        idle(3);
        chk("t9_ndone", ndone - d0, 1); chk("t9_ferr", last_ferr, 1);
        // SOC while disabled must not open a frame
        send_pair(1, 0); send_bit(1); idle(2);
        chk("t9_blocked", int'(frame_active), 0);
        enable = 1'b1;
        idle(4);

        // reset mid-byte
        b0 = nbytes; d0 = ndone;
        send_pair(1, 0); send_bit(0); send_bit(1); send_bit(1); send_bit(1);
        @(posedge osc_clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("rst_mid");
        idle(3);
        check_zero("rst_hold");
        reset = 1'b0;
        idle(4);
        chk("t10_nbytes", nbytes - b0, 0); chk("t10_ndone", ndone - d0, 0);
        send_pair(1, 0); send_byte(8'h3C, 1'b1); send_pair(0, 0); idle(6);
        chk("t10_data", last_data, 'h3C); chk("t10_len", last_len, 1);

        idle(4);
        chk("byte_queue_drained", bq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
